dvp_rgb565_capture: RTL and testbench



---
 rtl/capture_pkg.sv | 15 +
 rtl/dvp_byte_packer.sv | 37 +++
 rtl/dvp_rgb565_capture.sv | 165 ++++++++++++++++
 tb/tb_dvp_rgb565_capture.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/capture_pkg.sv
// Shared types and defaults for the DVP RGB565 capture front end.
package capture_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SKIP,
        ACTIVE
    } cap_state_t;

    localparam int DEF_H_ACTIVE    = 1280;
    localparam int DEF_V_ACTIVE    = 720;
    localparam int DEF_SKIP_FRAMES = 10;
    localparam int RGB565_W        = 16;

endpackage

// File: rtl/dvp_byte_packer.sv
// Pairs DVP bytes into RGB565 words; pix_stb is combinational so the parent
// can register pixel and framing flags in the same edge.
module dvp_byte_packer
    import capture_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                clr,
    input  logic                href,
    input  logic [7:0]          din,
    output logic                pix_stb,
    output logic [RGB565_W-1:0] pix_data
);

    logic       phase;
    logic [7:0] hi_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase   <= 1'b0;
            hi_byte <= 8'h00;
        end else begin
            if (!en || clr || !href)
                phase <= 1'b0;
            else
                phase <= ~phase;
            if (en && !clr && href && !phase)
                hi_byte <= din;
        end
    end

    // A frame restart on a phase-1 byte drops the half-built pixel.
    assign pix_stb  = en & ~clr & href & phase;
    assign pix_data = {hi_byte, din};

endmodule

// File: rtl/dvp_rgb565_capture.sv
// OV5640 DVP capture: frame skipping, RGB565 packing and sop/eop framing.
// Define CAPTURE_FRAME_CHECK_EN to enable the frame_err malformed-frame check.
module dvp_rgb565_capture
    import capture_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int SKIP_FRAMES = DEF_SKIP_FRAMES
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_done,
    input  logic                vsync,
    input  logic                href,
    input  logic [7:0]          din,
    output logic [RGB565_W-1:0] pixel,
    output logic                pixel_vld,
    output logic                sop,
    output logic                eop,
    output logic                frame_err
);

    localparam int HW = $clog2(H_ACTIVE + 1);
    localparam int VW = $clog2(V_ACTIVE + 1);
    localparam logic [HW-1:0] H_LAST = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] H_END  = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_LAST = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] V_END  = VW'(V_ACTIVE);
    localparam logic [7:0]    SKIP_N = 8'(SKIP_FRAMES);

    cap_state_t state;
    logic [7:0] skip_cnt;
    logic       vs_r, vs_d, href_r, href_d;
    logic [7:0] din_r;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;

    logic vs_rise, href_fall, active, frame_start;
    logic pix_stb, emit, emit_first, emit_last;
    logic [RGB565_W-1:0] pix_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_r   <= 1'b0;
            vs_d   <= 1'b0;
            href_r <= 1'b0;
            href_d <= 1'b0;
            din_r  <= 8'h00;
        end else begin
            vs_r   <= vsync;
            vs_d   <= vs_r;
            href_r <= href;
            href_d <= href_r;
            din_r  <= din;
        end
    end

    assign vs_rise   = vs_r & ~vs_d;
    assign href_fall = href_d & ~href_r;
    assign active    = cfg_done && (state == ACTIVE);
    // The vs_rise that ends skipping is also the first captured frame start.
    assign frame_start = cfg_done && vs_rise &&
                         ((state == ACTIVE) || (state == SKIP && skip_cnt == SKIP_N));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            skip_cnt <= 8'd0;
        end else if (!cfg_done) begin
            state    <= IDLE;
            skip_cnt <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= SKIP;
                    skip_cnt <= 8'd0;
                end
                SKIP: begin
                    if (vs_rise) begin
                        if (skip_cnt == SKIP_N)
                            state <= ACTIVE;
                        else
                            skip_cnt <= skip_cnt + 1'b1;
                    end
                end
                ACTIVE:  state <= ACTIVE;
                default: state <= IDLE;
            endcase
        end
    end

    dvp_byte_packer u_packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (active),
        .clr      (frame_start),
        .href     (href_r),
        .din      (din_r),
        .pix_stb  (pix_stb),
        .pix_data (pix_data)
    );

    // h_cnt saturates at all-ones (never below H_ACTIVE) so long lines stay suppressed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (frame_start || !active) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (href_fall) begin
            h_cnt <= '0;
            if (h_cnt != '0 && v_cnt != V_END)
                v_cnt <= v_cnt + 1'b1;
        end else if (pix_stb && h_cnt != '1) begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    assign emit       = pix_stb && (h_cnt < H_END) && (v_cnt < V_END);
    assign emit_first = emit && (h_cnt == '0) && (v_cnt == '0);
    assign emit_last  = emit && (h_cnt == H_LAST) && (v_cnt == V_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel     <= '0;
            pixel_vld <= 1'b0;
            sop       <= 1'b0;
            eop       <= 1'b0;
        end else begin
            pixel_vld <= emit;
            sop       <= emit_first;
            eop       <= emit_last;
            if (emit)
                pixel <= pix_data;
        end
    end

`ifdef CAPTURE_FRAME_CHECK_EN
    logic frm_open;
    logic err_trunc, err_line;

    assign err_trunc = active && vs_rise && frm_open;
    assign err_line  = active && href_fall && (h_cnt != '0) && (h_cnt != H_END) &&
                       (v_cnt < V_END);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frm_open  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= err_trunc | err_line;
            if (!active || frame_start)
                frm_open <= 1'b0;
            else if (emit_last)
                frm_open <= 1'b0;
            else if (emit_first)
                frm_open <= 1'b1;
        end
    end
`else
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_dvp_rgb565_capture.sv
// Directed bench for dvp_rgb565_capture with a 4x2 frame and 2 skipped frames.
module tb_dvp_rgb565_capture;

    localparam int H = 4;
    localparam int V = 2;
    localparam int SK = 2;

`ifdef CAPTURE_FRAME_CHECK_EN
    localparam int ERR_EXP = 1;
`else
    localparam int ERR_EXP = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_done = 1'b0;
    logic        vsync = 1'b0;
    logic        href = 1'b0;
    logic [7:0]  din = 8'h00;
    logic [15:0] pixel;
    logic        pixel_vld, sop, eop, frame_err;

    int n_chk = 0;
    int n_pass = 0;
    logic [17:0] mon_q[$];
    int err_cnt = 0;

    always #5 clk = ~clk;

    dvp_rgb565_capture #(
        .H_ACTIVE    (H),
        .V_ACTIVE    (V),
        .SKIP_FRAMES (SK)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_done  (cfg_done),
        .vsync     (vsync),
        .href      (href),
        .din       (din),
        .pixel     (pixel),
        .pixel_vld (pixel_vld),
        .sop       (sop),
        .eop       (eop),
        .frame_err (frame_err)
    );

    always @(negedge clk) begin
        if (pixel_vld) mon_q.push_back({sop, eop, pixel});
        if (frame_err) err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        href = 1'b1;
        din  = b;
        step();
    endtask

    task automatic line_end();
        href = 1'b0;
        din  = 8'h00;
        repeat (4) step();
    endtask

    task automatic send_line(input int li, input int nb);
        logic [3:0] hi, lo;
        hi = li[3:0];
        for (int j = 0; j < nb; j++) begin
            lo = j[3:0];
            send_byte({hi, lo});
        end
        line_end();
    endtask

    task automatic send_vsync();
        vsync = 1'b1;
        repeat (3) step();
        vsync = 1'b0;
        repeat (3) step();
    endtask

    task automatic send_frame(input int nl, input int nb0);
        send_vsync();
        for (int l = 0; l < nl; l++) send_line(l, (l == 0) ? nb0 : 8);
    endtask

    // Line li, pixel p carries bytes {li,2p},{li,2p+1}; sop on idx 0, eop on idx 7.
    function automatic logic [17:0] exp_ent(input int idx);
        logic [3:0] li, b0, b1;
        li = 4'(idx / H);
        b0 = 4'(2 * (idx % H));
        b1 = 4'(2 * (idx % H) + 1);
        return {(idx == 0), (idx == H * V - 1), li, b0, li, b1};
    endfunction

    task automatic chk_frame(input string tag, input int base);
        chk({tag, "_cnt"}, mon_q.size() - base, H * V);
        for (int i = 0; i < H * V; i++)
            if (base + i < mon_q.size()) chk($sformatf("%s_px%0d", tag, i), mon_q[base + i], exp_ent(i));
    endtask

    initial begin
        int base, ebase;

        @(posedge clk);
        #1;
        chk("rst_pixel", pixel, 0);
        chk("rst_vld", pixel_vld, 0);
        chk("rst_sop", sop, 0);
        chk("rst_eop", eop, 0);
        chk("rst_err", frame_err, 0);
        rst_n = 1'b1;
        repeat (2) step();
        cfg_done = 1'b1;
        repeat (2) step();

        // Two skipped frames, then a captured one.
        base = mon_q.size();
        ebase = err_cnt;
        send_frame(2, 8);
        send_frame(2, 8);
        chk("skip_none", mon_q.size() - base, 0);
        send_frame(2, 8);
        chk_frame("first", base);
        chk("first_err", err_cnt - ebase, 0);

        // Packing and 2-cycle latency.
        base = mon_q.size();
        send_vsync();
        send_byte(8'hF8);
        send_byte(8'h1F);
        href = 1'b1;
        din  = 8'h07;
        @(negedge clk);
        chk("lat_early", pixel_vld, 0);
        @(posedge clk);
        #1;
        din = 8'hE0;
        @(negedge clk);
        chk("lat_vld", pixel_vld, 1);
        chk("lat_pix", pixel, 16'hF81F);
        chk("lat_sop", sop, 1);
        @(posedge clk);
        #1;
        send_byte(8'h00);
        send_byte(8'h1F);
        send_byte(8'hFF);
        send_byte(8'hFF);
        line_end();
        send_line(1, 8);
        chk("pack_cnt", mon_q.size() - base, 8);
        if (mon_q.size() > base + 3) begin
            chk("pack_px1", mon_q[base + 1], {2'b00, 16'h07E0});
            chk("pack_px3", mon_q[base + 3], {2'b00, 16'hFFFF});
        end

        // Long first line plus a third line.
        base = mon_q.size();
        ebase = err_cnt;
        send_frame(3, 10);
        chk_frame("long", base);
        chk("long_err", err_cnt - ebase, ERR_EXP);

        // Truncated frame, then a complete one.
        base = mon_q.size();
        ebase = err_cnt;
        send_frame(1, 8);
        chk("trunc_cnt", mon_q.size() - base, 4);
        if (mon_q.size() > base) chk("trunc_sop", mon_q[base], {2'b10, 16'h0001});
        base = mon_q.size();
        send_frame(2, 8);
        chk("trunc_err", err_cnt - ebase, ERR_EXP);
        chk_frame("retry", base);

        // cfg_done drop mid-frame: pixel already in flight, then silence.
        base = mon_q.size();
        send_vsync();
        send_line(0, 8);
        for (int j = 0; j < 4; j++) send_byte({4'h1, 4'(j)});
        cfg_done = 1'b0;
        for (int j = 4; j < 8; j++) send_byte({4'h1, 4'(j)});
        line_end();
        chk("cfg_drop_cnt", mon_q.size() - base, 5);
        cfg_done = 1'b1;
        repeat (2) step();
        base = mon_q.size();
        send_frame(2, 8);
        send_frame(2, 8);
        chk("cfg_reskip", mon_q.size() - base, 0);
        send_frame(2, 8);
        chk_frame("cfg_again", base);

        // Asynchronous reset mid-line.
        send_vsync();
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        chk("arst_pre_vld", pixel_vld, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_pixel", pixel, 0);
        chk("arst_vld", pixel_vld, 0);
        chk("arst_sop", sop, 0);
        chk("arst_eop", eop, 0);
        chk("arst_err", frame_err, 0);
        href = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (2) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
